// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing the six-digit display between two level requesters.
// Optional idle timeout back to DEFAULT_NUM is enabled by defining DISP_TIMEOUT_EN.
module display_arbiter #(
    parameter int unsigned HOLD_CYCLES    = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
    parameter logic [23:0] DEFAULT_NUM    = 24'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [23:0] data0,
    input  logic [23:0] data1,
    output logic [1:0]  ack,
    output logic [23:0] num,
    output logic        src,
    output logic        busy
);

    localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);

    logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
    logic [23:0]     num_q, num_d;
    logic [1:0]      ack_q, ack_d;
    logic            src_q, src_d;
    logic            busy_q, busy_d;
    logic            rr_q, rr_d;
    logic            grant;
    logic            winner;

`ifdef DISP_TIMEOUT_EN
    localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);
    logic [IdleW-1:0] idle_q, idle_d;
`endif

    always_comb begin
        grant      = (hold_cnt_q == '0) && (req != 2'b00);
        // A lone requester wins outright; a tie goes to the round-robin pointer.
        winner     = (req == 2'b11) ? rr_q : req[1];
        hold_cnt_d = hold_cnt_q;
        num_d      = num_q;
        src_d      = src_q;
        rr_d       = rr_q;
        ack_d      = 2'b00;
        if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - CntW'(1);
        end
        if (grant) begin
            num_d      = winner ? data1 : data0;
            src_d      = winner;
            ack_d      = winner ? 2'b10 : 2'b01;
            hold_cnt_d = CntW'(HOLD_CYCLES);
            rr_d       = ~winner;
        end
`ifdef DISP_TIMEOUT_EN
        idle_d = idle_q;
        if (grant || (req != 2'b00)) begin
            idle_d = '0;
        end else if (hold_cnt_q == '0) begin
            if (idle_q == IdleW'(TIMEOUT_CYCLES - 1)) begin
                idle_d = '0;
                num_d  = DEFAULT_NUM;
            end else begin
                idle_d = idle_q + IdleW'(1);
            end
        end
`endif
        busy_d = (hold_cnt_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q <= '0;
            num_q      <= DEFAULT_NUM;
            ack_q      <= 2'b00;
            src_q      <= 1'b0;
            busy_q     <= 1'b0;
            rr_q       <= 1'b0;
`ifdef DISP_TIMEOUT_EN
            idle_q     <= '0;
`endif
        end else begin
            hold_cnt_q <= hold_cnt_d;
            num_q      <= num_d;
            ack_q      <= ack_d;
            src_q      <= src_d;
            busy_q     <= busy_d;
            rr_q       <= rr_d;
`ifdef DISP_TIMEOUT_EN
            idle_q     <= idle_d;
`endif
        end
    end

    assign ack  = ack_q;
    assign num  = num_q;
    assign src  = src_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter: table of cycle vectors plus reset and timeout sequences.
module tb_display_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [23:0] data0;
    logic [23:0] data1;
    logic [1:0]  ack;
    logic [23:0] num;
    logic        src;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    display_arbiter #(
        .HOLD_CYCLES   (4),
        .TIMEOUT_CYCLES(10),
        .DEFAULT_NUM   (24'h000000)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .data0(data0),
        .data1(data1),
        .ack  (ack),
        .num  (num),
        .src  (src),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic [23:0] d0;
        logic [23:0] d1;
        logic [1:0]  ack;
        logic [23:0] num;
        logic        src;
        logic        busy;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [1:0] r, input logic [23:0] d0, input logic [23:0] d1,
                       input logic [1:0] a, input logic [23:0] n, input logic s, input logic b);
        vec_t v;
        v.req = r; v.d0 = d0; v.d1 = d1; v.ack = a; v.num = n; v.src = s; v.busy = b;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outputs packed as {ack, num, src, busy}.
    function automatic logic [63:0] outs();
        return {36'd0, ack, num, src, busy};
    endfunction

    function automatic logic [63:0] pk(input logic [1:0] a, input logic [23:0] n,
                                       input logic s, input logic b);
        return {36'd0, a, n, s, b};
    endfunction

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 20) begin
            step();
            k++;
        end
        chk(name, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 2'b00; data0 = '0; data1 = '0;
        #1;
        chk("reset_outputs", outs(), pk(2'b00, 24'h000000, 1'b0, 1'b0));
        step();
        step();
        rst = 1'b0;

        // Single grant, busy for 4 cycles, a short pulse while busy is ignored.
        add(2'b01, 24'h123456, 24'h000000, 2'b01, 24'h123456, 1'b0, 1'b1);
        add(2'b00, 24'h000000, 24'h000000, 2'b00, 24'h123456, 1'b0, 1'b1);
        add(2'b00, 24'h000000, 24'h000000, 2'b00, 24'h123456, 1'b0, 1'b1);
        add(2'b01, 24'h999999, 24'h000000, 2'b00, 24'h123456, 1'b0, 1'b1);
        add(2'b00, 24'h000000, 24'h000000, 2'b00, 24'h123456, 1'b0, 1'b0);
        add(2'b00, 24'h000000, 24'h000000, 2'b00, 24'h123456, 1'b0, 1'b0);
        // Both requesting: pointer moved to 1 by the single grant above.
        add(2'b11, 24'hAAAAAA, 24'hBBBBBB, 2'b10, 24'hBBBBBB, 1'b1, 1'b1);
        add(2'b11, 24'hAAAAAA, 24'hBBBBBB, 2'b00, 24'hBBBBBB, 1'b1, 1'b1);
        add(2'b11, 24'hAAAAAA, 24'hBBBBBB, 2'b00, 24'hBBBBBB, 1'b1, 1'b1);
        add(2'b11, 24'hAAAAAA, 24'hBBBBBB, 2'b00, 24'hBBBBBB, 1'b1, 1'b1);
        add(2'b11, 24'hAAAAAA, 24'hBBBBBB, 2'b00, 24'hBBBBBB, 1'b1, 1'b0);
        add(2'b11, 24'hAAAAAA, 24'hBBBBBB, 2'b01, 24'hAAAAAA, 1'b0, 1'b1);
        // Source 1 arrives one cycle after a source-0 grant and waits out the hold.
        add(2'b10, 24'hAAAAAA, 24'hCCCCCC, 2'b00, 24'hAAAAAA, 1'b0, 1'b1);
        add(2'b10, 24'hAAAAAA, 24'hCCCCCC, 2'b00, 24'hAAAAAA, 1'b0, 1'b1);
        add(2'b10, 24'hAAAAAA, 24'hCCCCCC, 2'b00, 24'hAAAAAA, 1'b0, 1'b1);
        add(2'b10, 24'hAAAAAA, 24'hCCCCCC, 2'b00, 24'hAAAAAA, 1'b0, 1'b0);
        add(2'b10, 24'hAAAAAA, 24'hCCCCCC, 2'b10, 24'hCCCCCC, 1'b1, 1'b1);
        add(2'b00, 24'h000000, 24'h000000, 2'b00, 24'hCCCCCC, 1'b1, 1'b1);
        add(2'b00, 24'h000000, 24'h000000, 2'b00, 24'hCCCCCC, 1'b1, 1'b1);
        add(2'b00, 24'h000000, 24'h000000, 2'b00, 24'hCCCCCC, 1'b1, 1'b1);
        add(2'b00, 24'h000000, 24'h000000, 2'b00, 24'hCCCCCC, 1'b1, 1'b0);
        // Single grant to source 1 moved the pointer back to 0.
        add(2'b11, 24'hDDDDDD, 24'hEEEEEE, 2'b01, 24'hDDDDDD, 1'b0, 1'b1);

        foreach (vq[i]) begin
            req = vq[i].req; data0 = vq[i].d0; data1 = vq[i].d1;
            step();
            chk($sformatf("vec%0d", i), outs(),
                pk(vq[i].ack, vq[i].num, vq[i].src, vq[i].busy));
        end

        // Asynchronous reset in the middle of a hold.
        #2 rst = 1'b1;
        #1;
        chk("async_reset_mid_hold", outs(), pk(2'b00, 24'h000000, 1'b0, 1'b0));
        rst = 1'b0;
        req = 2'b01; data0 = 24'h111111;
        step();
        chk("grant_after_reset", outs(), pk(2'b01, 24'h111111, 1'b0, 1'b1));
        req = 2'b00;
        step();
        chk("ack_one_cycle", outs(), pk(2'b00, 24'h111111, 1'b0, 1'b1));
        wait_idle("idle_before_timeout_test");

        // Idle behaviour after a grant of 654321.
        req = 2'b01; data0 = 24'h654321;
        step();
        chk("grant_654321", outs(), pk(2'b01, 24'h654321, 1'b0, 1'b1));
        req = 2'b00; data0 = 24'h0;
        wait_idle("busy_falls");
`ifdef DISP_TIMEOUT_EN
        for (int i = 0; i < 9; i++) step();
        chk("timeout_not_yet", outs(), pk(2'b00, 24'h654321, 1'b0, 1'b0));
        step();
        chk("timeout_default", outs(), pk(2'b00, 24'h000000, 1'b0, 1'b0));
`else
        for (int i = 0; i < 10; i++) step();
        chk("hold_after_10", outs(), pk(2'b00, 24'h654321, 1'b0, 1'b0));
        for (int i = 0; i < 90; i++) step();
        chk("hold_after_100", outs(), pk(2'b00, 24'h654321, 1'b0, 1'b0));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
